// File: rtl/seg7_time_display.sv
`default_nettype none
// ============================================================================
// Module  : seg7_time_display
// Brief   : Four-digit multiplexed 7-segment driver for a clock display.
//           Shows HH.MM or MM.SS, blinks the field being edited, and inserts
//           an all-dark interval at the start of every digit slot to stop
//           ghosting between neighbouring digits.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_time_display #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 1_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic       pos,
  input  logic       edit_en,
  input  logic       page,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int c_SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
  // One extra bit so the comparison stays meaningful if BLANK_CYC is near 2^W.
  localparam logic [c_SCAN_W:0]    c_BLANK      = (c_SCAN_W + 1)'(BLANK_CYC);

  logic [c_SCAN_W-1:0]  r_scan_cnt;
  logic [c_BLINK_W-1:0] r_blink_cnt;
  logic [1:0]           r_digit_idx;
  logic                 r_blink_phase;

  logic [3:0] w_digit;
  logic [6:0] w_seg_dec;
  logic       w_in_blank;
  logic       w_sel_field;
  logic       w_slot_dark;
  logic [3:0] w_an_next;
  logic       w_dp_next;

  // Slot timer and digit index: index advances once per full slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
    end else if (r_scan_cnt == c_SCAN_LAST) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_scan_cnt  <= r_scan_cnt + 1'b1;
    end
  end

  // Blink timer: phase flips every BLINK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == c_BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  // Pick the BCD digit for the current slot according to the page.
  always_comb begin
    w_digit = 4'd0;
    case (r_digit_idx)
      2'd3:    w_digit = page ? m2 : h2;
      2'd2:    w_digit = page ? m1 : h1;
      2'd1:    w_digit = page ? s2 : m2;
      default: w_digit = page ? s1 : m1;
    endcase
  end

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  always_comb begin
    w_seg_dec = 7'h3F;
    case (w_digit)
      4'd0:    w_seg_dec = 7'h40;
      4'd1:    w_seg_dec = 7'h79;
      4'd2:    w_seg_dec = 7'h24;
      4'd3:    w_seg_dec = 7'h30;
      4'd4:    w_seg_dec = 7'h19;
      4'd5:    w_seg_dec = 7'h12;
      4'd6:    w_seg_dec = 7'h02;
      4'd7:    w_seg_dec = 7'h78;
      4'd8:    w_seg_dec = 7'h00;
      4'd9:    w_seg_dec = 7'h10;
      default: w_seg_dec = 7'h3F;
    endcase
  end

  // Anode/dp selection: anti-ghost interval, edit blinking, colon-like dp.
  always_comb begin
    w_in_blank  = ({1'b0, r_scan_cnt} < c_BLANK);
    // Hours live in the upper pair on page 0 only; minutes are the lower
    // pair on page 0 and the upper pair on page 1.
    if (pos) begin
      w_sel_field = ~page & r_digit_idx[1];
    end else begin
      w_sel_field = page ? r_digit_idx[1] : ~r_digit_idx[1];
    end
    w_slot_dark = w_in_blank | (edit_en & r_blink_phase & w_sel_field);
    w_an_next   = w_slot_dark ? 4'b1111 : ~(4'b0001 << r_digit_idx);
    w_dp_next   = ~((r_digit_idx == 2'd2) & ~r_blink_phase & ~w_slot_dark);
  end

  // Registered display outputs, one cycle behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= w_an_next;
      seg <= w_seg_dec;
      dp  <= w_dp_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_time_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_time_display
// Brief   : Scoreboard bench for seg7_time_display with small dividers.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_time_display;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int BLINK_DIV = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s1 = 0, s2 = 0, m1 = 0, m2 = 0, h1 = 0, h2 = 0;
  logic       pos = 1'b0, edit_en = 1'b0, page = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];

  seg7_time_display #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
    .pos(pos), .edit_en(edit_en), .page(page),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return t[d];
  endfunction

  // Reference model state
  int m_scan = 0, m_blink = 0, m_idx = 0;
  bit m_phase = 0;

  function automatic logic [11:0] expect_out(input int idx, input int scn, input bit ph);
    logic [3:0] d [4];
    logic [3:0] a;
    bit dark;
    if (!page) begin d[3] = h2; d[2] = h1; d[1] = m2; d[0] = m1; end
    else       begin d[3] = m2; d[2] = m1; d[1] = s2; d[0] = s1; end
    dark = (scn < BLANK_CYC);
    if (edit_en && ph) begin
      if (pos && !page && idx >= 2)  dark = 1;
      if (!pos && !page && idx <= 1) dark = 1;
      if (!pos && page && idx >= 2)  dark = 1;
    end
    a = 4'b1111;
    if (!dark) a[idx] = 1'b0;
    return {a, seg_of(d[idx]), (idx == 2 && !ph && !dark) ? 1'b0 : 1'b1};
  endfunction

  // Model: predict the output of each edge and push it to the scoreboard.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_scan = 0; m_blink = 0; m_idx = 0; m_phase = 0;
    end else begin
      exp_q.push_back(expect_out(m_idx, m_scan, m_phase));
      if (m_scan == SCAN_DIV - 1) begin m_scan = 0; m_idx = (m_idx + 1) % 4; end
      else m_scan++;
      if (m_blink == BLINK_DIV - 1) begin m_blink = 0; m_phase = ~m_phase; end
      else m_blink++;
    end
  end

  // Monitor: compare DUT outputs on the falling edge.
  always @(negedge clk) begin
    logic [11:0] e;
    chk("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    if (!rst_n) begin
      chk("reset_outputs", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scoreboard", {an, seg, dp}, e);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // First lit slot must be idx0, BLANK_CYC+1 edges after release.
  task automatic check_startup(input logic [6:0] seg0);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (an == 4'hF && n < 20);
    chk("startup_latency", n, BLANK_CYC + 1);
    chk("startup_an", an, 4'b1110);
    chk("startup_seg", seg, seg0);
  endtask

  initial begin
    logic [3:0] ans [4];
    logic [6:0] sgs [4];
    ans = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sgs = '{7'h00, 7'h12, 7'h24, 7'h79};

    h2 = 1; h1 = 2; m2 = 5; m1 = 8; page = 0; edit_en = 0;
    step(3);
    rst_n = 1;
    check_startup(7'h00);
    for (int k = 1; k < 4; k++) begin
      repeat (SCAN_DIV) @(posedge clk);
      #1;
      chk("scan_an", an, ans[k]);
      chk("scan_seg", seg, sgs[k]);
      chk("scan_dp", dp, (k == 2) ? 1'b0 : 1'b1);
    end
    step(140);

    page = 1; m2 = 5; m1 = 9; s2 = 0; s1 = 7;
    step(70);

    page = 0; edit_en = 1; pos = 1;
    step(140);
    pos = 0;
    step(140);
    page = 1;
    step(140);
    pos = 1;
    step(140);

    edit_en = 0; s1 = 4'hC;
    step(40);

    step(5);
    rst_n = 0;
    #1;
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_dp", dp, 1'b1);
    chk("async_rst_cnt", {dut.r_digit_idx, dut.r_blink_phase}, 3'd0);
    step(2);
    rst_n = 1;
    check_startup(7'h3F);
    step(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
